// File: rtl/freq_ctrl_pkg.sv
// freq_ctrl_pkg: shared encodings and default widths for the frequency sweep sequencer
package freq_ctrl_pkg;
  localparam int SEL_W_DEF = 3;
  localparam int DWELL_W_DEF = 16;
  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_WRAP, MODE_PINGPONG} mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DWELL} state_e;
endpackage

// File: rtl/freq_sweep_ctrl_if.sv
// freq_sweep_ctrl_if: control, divider tick and status signals of the sweep sequencer
interface freq_sweep_ctrl_if
  import freq_ctrl_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);
  logic start;
  logic abort;
  logic [1:0] mode;
  logic [SEL_W-1:0] sel_lo;
  logic [SEL_W-1:0] sel_hi;
  logic [DWELL_W-1:0] dwell;
  logic div_tick;
  logic [SEL_W-1:0] freq_cntrl;
  logic busy;
  logic step_pulse;
  logic done;
  logic cfg_err;
  logic forced;
  modport master (
    output start, abort, mode, sel_lo, sel_hi, dwell, div_tick,
    input freq_cntrl, busy, step_pulse, done, cfg_err, forced
  );
  modport slave (
    input start, abort, mode, sel_lo, sel_hi, dwell, div_tick,
    output freq_cntrl, busy, step_pulse, done, cfg_err, forced
  );
endinterface

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter whose expire marks the last counted cycle
module dwell_timer #(
  parameter int W = 16
) (
  input logic clk_in,
  input logic rst,
  input logic load,
  input logic en,
  input logic [W-1:0] load_val,
  output logic expire
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (en && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign expire = cnt_q == W'(1);
endmodule

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: steps the divider select through a range, applying changes only on period boundaries
module freq_sweep_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int TICK_TO = 1023,
  parameter int RESET_SEL = 0
) (
  input logic clk_in,
  input logic rst,
  freq_sweep_ctrl_if.slave bus
);
  localparam int TW = TICK_TO > 1 ? $clog2(TICK_TO + 1) : 1;
  state_e st_q, st_d;
  mode_e mode_q, mode_d;
  logic [SEL_W-1:0] freq_q, freq_d, tgt_q, tgt_d, lo_q, lo_d, hi_q, hi_d, nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic dir_q, dir_d, step_q, step_d, done_q, done_d;
  logic cfg_err_q, cfg_err_d, forced_q, forced_d;
  logic dw_exp, to_exp, to_hit, at_lo, at_hi, pp_up, fin, bad;

  // Both timers reload whenever their state is not active, so each entry starts fresh.
  dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk_in(clk_in), .rst(rst), .load(st_q != ST_DWELL), .en(st_q == ST_DWELL),
    .load_val(dwell_q), .expire(dw_exp)
  );
  dwell_timer #(.W(TW)) u_tick_to (
    .clk_in(clk_in), .rst(rst), .load(st_q != ST_PEND), .en(st_q == ST_PEND),
    .load_val(TW'(TICK_TO)), .expire(to_exp)
  );

  assign to_hit = (TICK_TO != 0) && to_exp;
  assign at_lo = freq_q == lo_q;
  assign at_hi = freq_q == hi_q;
  assign pp_up = dir_q ? !at_hi : at_lo;
  assign fin = (mode_q == MODE_UP && at_hi) || (mode_q == MODE_DOWN && at_lo);
  assign bad = bus.sel_lo > bus.sel_hi || bus.dwell == '0;
  assign nxt = (mode_q == MODE_WRAP && at_hi) ? lo_q :
               (mode_q == MODE_PINGPONG && lo_q == hi_q) ? freq_q :
               (mode_q == MODE_DOWN || (mode_q == MODE_PINGPONG && !pp_up)) ? freq_q - 1'b1 :
               freq_q + 1'b1;

  always_comb begin
    st_d = st_q;
    mode_d = mode_q;
    freq_d = freq_q;
    tgt_d = tgt_q;
    lo_d = lo_q;
    hi_d = hi_q;
    dwell_d = dwell_q;
    dir_d = dir_q;
    step_d = 1'b0;
    done_d = 1'b0;
    cfg_err_d = cfg_err_q;
    forced_d = forced_q;
    if (bus.abort) begin
      st_d = ST_IDLE;
    end else if (st_q == ST_IDLE && bus.start) begin
      mode_d = mode_e'(bus.mode);
      lo_d = bus.sel_lo;
      hi_d = bus.sel_hi;
      dwell_d = bus.dwell;
      cfg_err_d = bad;
      forced_d = 1'b0;
      st_d = bad ? ST_IDLE : ST_PEND;
      tgt_d = mode_e'(bus.mode) == MODE_DOWN ? bus.sel_hi : bus.sel_lo;
      dir_d = mode_e'(bus.mode) != MODE_DOWN;
    end else if (st_q == ST_PEND && (bus.div_tick || to_hit)) begin
      freq_d = tgt_q;
      step_d = 1'b1;
      forced_d = forced_q | !bus.div_tick;
      st_d = ST_DWELL;
    end else if (st_q == ST_DWELL && dw_exp) begin
      st_d = fin ? ST_IDLE : ST_PEND;
      done_d = fin;
      tgt_d = fin ? tgt_q : nxt;
      dir_d = mode_q == MODE_PINGPONG ? pp_up : dir_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      st_q <= ST_IDLE;
      mode_q <= MODE_UP;
      freq_q <= SEL_W'(RESET_SEL);
      tgt_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      dwell_q <= '0;
      dir_q <= 1'b0;
      step_q <= 1'b0;
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      st_q <= st_d;
      mode_q <= mode_d;
      freq_q <= freq_d;
      tgt_q <= tgt_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      dwell_q <= dwell_d;
      dir_q <= dir_d;
      step_q <= step_d;
      done_q <= done_d;
      cfg_err_q <= cfg_err_d;
      forced_q <= forced_d;
    end
  end

  assign bus.freq_cntrl = freq_q;
  assign bus.busy = st_q != ST_IDLE;
  assign bus.step_pulse = step_q;
  assign bus.done = done_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.forced = forced_q;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed and random stimulus checked against a select-list reference model
module tb_freq_sweep_ctrl;
  localparam int SW = 3;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int RS = 0;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  freq_sweep_ctrl_if #(.SEL_W(SW), .DWELL_W(DW)) bus ();
  freq_sweep_ctrl #(.SEL_W(SW), .DWELL_W(DW), .TICK_TO(TO), .RESET_SEL(RS)) dut (
    .clk_in(clk_in), .rst(rst), .bus(bus)
  );
  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;
  int cyc = 0, steps_seen = 0, dones_seen = 0;
  int c_mode, c_lo, c_hi, c_dwell;
  int m_freq = RS, m_dwell = 0, wait_cnt = 0, hold_left = 0;
  bit m_busy, m_step, m_done, m_cfg, m_forced, waiting;
  int seq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  // Whole list of selects the sweep will visit; endless modes get a long prefix.
  function automatic void build(int mode, int lo, int hi);
    int n, p;
    n = hi - lo;
    seq.delete();
    if (mode == 0) for (int v = lo; v <= hi; v++) seq.push_back(v);
    else if (mode == 1) for (int v = hi; v >= lo; v--) seq.push_back(v);
    else for (int i = 0; i < 1024; i++) begin
      if (n == 0) seq.push_back(lo);
      else if (mode == 2) seq.push_back(lo + i % (n + 1));
      else begin
        p = i % (2 * n);
        seq.push_back(p <= n ? lo + p : lo + 2 * n - p);
      end
    end
  endfunction

  task automatic model(input bit s, input bit a, input bit t, input bit r);
    m_step = 0;
    m_done = 0;
    if (r) begin
      m_freq = RS; m_busy = 0; m_cfg = 0; m_forced = 0; waiting = 0;
    end else if (a) begin
      m_busy = 0; waiting = 0;
    end else if (!m_busy && s) begin
      m_forced = 0;
      m_cfg = c_lo > c_hi || c_dwell == 0;
      if (!m_cfg) begin
        build(c_mode, c_lo, c_hi);
        m_dwell = c_dwell; m_busy = 1; waiting = 1; wait_cnt = 0;
      end
    end else if (m_busy && waiting) begin
      wait_cnt++;
      if (t || wait_cnt == TO) begin
        m_freq = seq.pop_front();
        m_step = 1;
        if (!t) m_forced = 1;
        waiting = 0;
        hold_left = m_dwell;
      end
    end else if (m_busy) begin
      hold_left--;
      if (hold_left == 0) begin
        if (seq.size() == 0) begin
          m_busy = 0; m_done = 1;
        end else begin
          waiting = 1; wait_cnt = 0;
        end
      end
    end
  endtask

  task automatic set_cfg(input int mode, input int lo, input int hi, input int dw);
    c_mode = mode; c_lo = lo; c_hi = hi; c_dwell = dw;
    bus.mode = 2'(mode);
    bus.sel_lo = SW'(lo);
    bus.sel_hi = SW'(hi);
    bus.dwell = DW'(dw);
  endtask

  task automatic cycle(input bit s, input bit a, input bit t, input bit r);
    bus.start = s;
    bus.abort = a;
    bus.div_tick = t;
    rst = r;
    @(posedge clk_in);
    model(s, a, t, r);
    #1;
    chk("freq_cntrl", bus.freq_cntrl, m_freq);
    chk("busy", bus.busy, m_busy);
    chk("step_pulse", bus.step_pulse, m_step);
    chk("done", bus.done, m_done);
    chk("cfg_err", bus.cfg_err, m_cfg);
    chk("forced", bus.forced, m_forced);
    if (bus.step_pulse) steps_seen++;
    if (bus.done) dones_seen++;
    cyc++;
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.div_tick = 0;
    set_cfg(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    set_cfg(0, 1, 3, 4);
    steps_seen = 0; dones_seen = 0;
    while (cyc % 10 != 5) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (60) cycle(0, 0, cyc % 10 == 0, 0);
    chk("up_steps", steps_seen, 3);
    chk("up_done", dones_seen, 1);
    chk("up_last", bus.freq_cntrl, 3);
    chk("up_forced", bus.forced, 0);

    set_cfg(3, 0, 2, 2);
    steps_seen = 0; dones_seen = 0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 200 && steps_seen < 7; i++) cycle(0, 0, cyc % 3 == 0, 0);
    chk("pp_steps", steps_seen, 7);
    cycle(0, 1, 0, 0);
    chk("pp_abort_busy", bus.busy, 0);
    chk("pp_hold", bus.freq_cntrl, 2);
    chk("pp_no_done", dones_seen, 0);
    repeat (3) cycle(0, 0, 1, 0);

    set_cfg(0, 5, 2, 3);
    cycle(1, 0, 0, 0);
    chk("bad_range_err", bus.cfg_err, 1);
    chk("bad_range_busy", bus.busy, 0);
    chk("bad_range_hold", bus.freq_cntrl, 2);
    set_cfg(0, 1, 2, 0);
    cycle(1, 0, 0, 0);
    chk("bad_dwell_err", bus.cfg_err, 1);
    set_cfg(1, 1, 2, 1);
    cycle(1, 0, 0, 0);
    chk("good_clr_err", bus.cfg_err, 0);
    chk("good_busy", bus.busy, 1);
    repeat (20) cycle(0, 0, cyc % 2 == 0, 0);

    set_cfg(2, 0, 7, 3);
    cycle(1, 0, 0, 0);
    repeat (7) cycle(0, 0, 0, 0);
    chk("to_early", bus.step_pulse, 0);
    cycle(0, 0, 0, 0);
    chk("to_step", bus.step_pulse, 1);
    chk("to_forced", bus.forced, 1);
    chk("to_sel", bus.freq_cntrl, 0);
    repeat (40) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);

    set_cfg(0, 0, 7, 5);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    chk("abort_tick_busy", bus.busy, 0);
    chk("abort_tick_step", bus.step_pulse, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("col_step", bus.step_pulse, 1);
    repeat (3) cycle(1, 0, 1, 0);
    chk("dwell_ignore_sel", bus.freq_cntrl, 0);
    chk("dwell_ignore_step", bus.step_pulse, 0);

    cycle(0, 0, 0, 1);
    chk("rst_sel", bus.freq_cntrl, RS);
    chk("rst_busy", bus.busy, 0);
    chk("rst_forced", bus.forced, 0);
    dones_seen = 0;
    set_cfg(0, 2, 3, 1);
    cycle(1, 0, 0, 0);
    repeat (20) cycle(0, 0, cyc % 2 == 0, 0);
    chk("rst_restart_done", dones_seen, 1);
    chk("rst_restart_sel", bus.freq_cntrl, 3);

    for (int i = 0; i < 3000; i++) begin
      bit s, a, t, r;
      s = $urandom % 16 == 0;
      a = $urandom % 64 == 0;
      t = $urandom % 3 == 0;
      r = $urandom % 400 == 0;
      if (s) set_cfg($urandom % 4, $urandom % 8, $urandom % 8, $urandom % 5);
      cycle(s, a, t, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
